// File: rtl/sb_arbiter.sv
// sb_arbiter: two-master system bus arbiter.
// Grants the bus to master 1 or master 2 with round-robin priority.
// Locked transfers keep the current owner in place.
// Masters that a slave has split are masked until a release pulse arrives.
// A tenure counter limits how long one master holds the bus while the other waits.
module sb_arbiter #(
  parameter int MAX_TENURE   = 16,
  parameter int TENURE_WIDTH = 5
) (
  input  logic       sb_clk,
  input  logic       sb_resetn,
  input  logic       sb_busreq_m1,
  input  logic       sb_busreq_m2,
  input  logic       sb_lock_m1,
  input  logic       sb_lock_m2,
  input  logic [1:0] sb_trans,
  input  logic       sb_ready,
  input  logic [1:0] sb_resp,
  input  logic [1:0] sb_split_s1,
  input  logic [1:0] sb_split_s2,
  input  logic [1:0] sb_split_s3,
  output logic       sb_grant_m1,
  output logic       sb_grant_m2,
  output logic       sb_master,
  output logic       sb_mastlock,
  output logic [1:0] sb_split_mask
);

  localparam logic [1:0] TRANS_IDLE = 2'd0;
  localparam logic [1:0] RESP_SPLIT = 2'd3;
  localparam logic [TENURE_WIDTH-1:0] TENURE_LAST = TENURE_WIDTH'(MAX_TENURE - 1);
  localparam logic [TENURE_WIDTH-1:0] TENURE_ONE  = TENURE_WIDTH'(1);
  localparam logic [TENURE_WIDTH-1:0] TENURE_ZERO = TENURE_WIDTH'(0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN_M1 = 2'd1,
    ST_OWN_M2 = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [TENURE_WIDTH-1:0] tenure_r;
  logic [TENURE_WIDTH-1:0] tenure_s;
  logic                    last_m2_r;   // 1: master 2 was granted most recently
  logic                    last_m2_s;
  logic [1:0]              mask_r;
  logic [1:0]              mask_s;
  logic                    grant_m1_r;
  logic                    grant_m2_r;
  logic                    master_r;
  logic                    mastlock_r;
  logic                    mastlock_s;

  logic [1:0]              release_s;
  logic [1:0]              set_s;
  logic                    split_now_s;
  logic                    elig_m1_s;
  logic                    elig_m2_s;
  logic                    owner_req_s;
  logic                    other_elig_s;
  logic                    tenure_full_s;
  logic                    rearb_s;

  assign sb_grant_m1   = grant_m1_r;
  assign sb_grant_m2   = grant_m2_r;
  assign sb_master     = master_r;
  assign sb_mastlock   = mastlock_r;
  assign sb_split_mask = mask_r;

  // Eligibility, split-mask update (a set beats a same-cycle release) and re-arbitration trigger.
  always_comb begin
    release_s     = sb_split_s1 | sb_split_s2 | sb_split_s3;
    split_now_s   = (sb_resp == RESP_SPLIT) && sb_ready;
    elig_m1_s     = sb_busreq_m1 && !mask_r[0];
    elig_m2_s     = sb_busreq_m2 && !mask_r[1];
    tenure_full_s = (tenure_r == TENURE_LAST);
    set_s         = 2'b00;
    owner_req_s   = 1'b0;
    other_elig_s  = 1'b0;
    rearb_s       = 1'b0;
    case (state_r)
      ST_OWN_M1: begin
        set_s        = {1'b0, split_now_s};
        owner_req_s  = sb_busreq_m1;
        other_elig_s = elig_m2_s;
      end
      ST_OWN_M2: begin
        set_s        = {split_now_s, 1'b0};
        owner_req_s  = sb_busreq_m2;
        other_elig_s = elig_m1_s;
      end
      default: begin
        set_s        = 2'b00;
        owner_req_s  = 1'b0;
        other_elig_s = 1'b0;
      end
    endcase
    mask_s = (mask_r & ~release_s) | set_s;
    if (state_r == ST_IDLE) begin
      rearb_s = 1'b0;
    end else if (split_now_s) begin
      rearb_s = 1'b1;
    end else if (mastlock_r) begin
      rearb_s = 1'b0;
    end else begin
      rearb_s = !owner_req_s
             || (sb_ready && (sb_trans == TRANS_IDLE) && other_elig_s)
             || (tenure_full_s && other_elig_s);
    end
  end

  // Next-state selection: IDLE contest by round-robin, handover to the other master on an event.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (elig_m1_s && elig_m2_s) begin
          if (last_m2_r) begin
            state_s = ST_OWN_M1;
          end else begin
            state_s = ST_OWN_M2;
          end
        end else if (elig_m1_s) begin
          state_s = ST_OWN_M1;
        end else if (elig_m2_s) begin
          state_s = ST_OWN_M2;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_OWN_M1: begin
        if (!rearb_s) begin
          state_s = ST_OWN_M1;
        end else if (elig_m2_s) begin
          state_s = ST_OWN_M2;
        end else if (elig_m1_s && !split_now_s) begin
          state_s = ST_OWN_M1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_OWN_M2: begin
        if (!rearb_s) begin
          state_s = ST_OWN_M2;
        end else if (elig_m1_s) begin
          state_s = ST_OWN_M1;
        end else if (elig_m2_s && !split_now_s) begin
          state_s = ST_OWN_M2;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Tenure counter, round-robin history and the incoming owner's lock.
  always_comb begin
    tenure_s   = tenure_r;
    last_m2_s  = last_m2_r;
    mastlock_s = 1'b0;
    if ((state_s != state_r) || (state_s == ST_IDLE)) begin
      tenure_s = TENURE_ZERO;
    end else if (mastlock_r || tenure_full_s) begin
      tenure_s = tenure_r;
    end else begin
      tenure_s = tenure_r + TENURE_ONE;
    end
    case (state_s)
      ST_OWN_M1: begin
        last_m2_s  = 1'b0;
        mastlock_s = sb_lock_m1;
      end
      ST_OWN_M2: begin
        last_m2_s  = 1'b1;
        mastlock_s = sb_lock_m2;
      end
      default: begin
        last_m2_s  = last_m2_r;
        mastlock_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything and gives master 1 the first contest.
  always_ff @(posedge sb_clk or negedge sb_resetn) begin
    if (!sb_resetn) begin
      state_r    <= ST_IDLE;
      tenure_r   <= TENURE_ZERO;
      last_m2_r  <= 1'b1;
      mask_r     <= 2'b00;
      grant_m1_r <= 1'b0;
      grant_m2_r <= 1'b0;
      master_r   <= 1'b0;
      mastlock_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      tenure_r   <= tenure_s;
      last_m2_r  <= last_m2_s;
      mask_r     <= mask_s;
      grant_m1_r <= (state_s == ST_OWN_M1);
      grant_m2_r <= (state_s == ST_OWN_M2);
      master_r   <= (state_s == ST_OWN_M1);
      mastlock_r <= mastlock_s;
    end
  end

endmodule
